// File: rtl/cm0_wic_pkg.sv
// Shared types and line-index helpers for the wake-up interrupt controller.
package cm0_wic_pkg;

    localparam int WICLINES_DEFAULT = 34;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_REQ    = 2'b01,
        ST_ON     = 2'b11,
        ST_DISARM = 2'b10
    } wic_state_e;

    // The two highest sense lines are always NMI and RXEV; IRQs fill the rest.
    function automatic int nmi_idx(input int wiclines);
        return wiclines - 2;
    endfunction

    function automatic int rxev_idx(input int wiclines);
        return wiclines - 1;
    endfunction

endpackage

// File: rtl/cm0_wic_line.sv
// One WIC sense line: sensitivity bit plus sticky pending capture.
module cm0_wic_line (
    input  logic sclk,
    input  logic hreset_n,
    input  logic load_en_i,
    input  logic clear_i,
    input  logic capture_en_i,
    input  logic mask_i,
    input  logic line_i,
    output logic sense_o,
    output logic pend_o,
    output logic pend_nxt_o
);

    logic sense_q, sense_d;
    logic pend_q, pend_d;

    always_comb begin
        // NOTE: every comb output gets its hold value first, so no latch can be inferred.
        sense_d = sense_q;
        pend_d  = pend_q;
        if (clear_i) begin
            sense_d = 1'b0;
            pend_d  = 1'b0;
        end else begin
            if (load_en_i) begin
                sense_d = mask_i;
            end
            // Capture uses the already-registered sense, so a line high at load time
            // shows up one cycle after the load.
            if (capture_en_i && sense_q && line_i) begin
                pend_d = 1'b1;
            end
        end
    end

    // NOTE: asynchronous active-low reset, and sequential state only ever takes non-blocking (<=) updates.
    always_ff @(posedge sclk or negedge hreset_n) begin
        if (!hreset_n) begin
            sense_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sense_q <= sense_d;
            pend_q  <= pend_d;
        end
    end

    assign sense_o    = sense_q;
    assign pend_o     = pend_q;
    assign pend_nxt_o = pend_d;

endmodule

// File: rtl/cm0_wic_ctl.sv
// WIC top: core/PMU WIC-mode handshake FSM, per-line sense/pend array and wakeup.
module cm0_wic_ctl
    import cm0_wic_pkg::*;
#(
    parameter int WICLINES = WICLINES_DEFAULT
) (
    input  logic                sclk,
    input  logic                hreset_n,
    input  logic                wic_en_req_i,
    output logic                wic_en_ack_o,
    output logic                wic_ds_req_n_o,
    input  logic                wic_ds_ack_n_i,
    input  logic                wic_load_i,
    input  logic                wic_clear_i,
    input  logic [31:0]         wic_mask_isr_i,
    input  logic                wic_mask_nmi_i,
    input  logic                wic_mask_rxev_i,
    input  logic [31:0]         irq_i,
    input  logic                nmi_i,
    input  logic                rxev_i,
    output logic [WICLINES-1:0] wic_sense_o,
    output logic [WICLINES-1:0] wic_pend_o,
    output logic                wakeup_o
);

    localparam int NMI_IDX  = nmi_idx(WICLINES);
    localparam int RXEV_IDX = rxev_idx(WICLINES);

    wic_state_e state_q, state_d;
    logic       wakeup_q;
    logic       load_en, capture_en;

    logic [WICLINES-1:0] mask_vec, line_vec, pend_nxt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:    if (wic_en_req_i) state_d = ST_REQ;
            // A withdrawn request wins over a coincident ack; DISARM then waits the ack out.
            ST_REQ:    if (!wic_en_req_i) state_d = ST_DISARM;
                       else if (!wic_ds_ack_n_i) state_d = ST_ON;
            ST_ON:     if (!wic_en_req_i) state_d = ST_DISARM;
            ST_DISARM: if (wic_ds_ack_n_i) state_d = ST_OFF;
            default:   state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge sclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= ST_OFF;
            wakeup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wakeup_q <= |pend_nxt;
        end
    end

    assign wic_ds_req_n_o = (state_q == ST_OFF) || (state_q == ST_DISARM);
    assign wic_en_ack_o   = (state_q == ST_ON);
    assign wakeup_o       = wakeup_q;

    assign load_en    = wic_load_i && (state_q == ST_ON);
    assign capture_en = (state_q == ST_ON) || (state_q == ST_DISARM);

    always_comb begin
        mask_vec               = '0;
        line_vec               = '0;
        mask_vec[WICLINES-3:0] = wic_mask_isr_i[WICLINES-3:0];
        line_vec[WICLINES-3:0] = irq_i[WICLINES-3:0];
        mask_vec[NMI_IDX]      = wic_mask_nmi_i;
        line_vec[NMI_IDX]      = nmi_i;
        mask_vec[RXEV_IDX]     = wic_mask_rxev_i;
        line_vec[RXEV_IDX]     = rxev_i;
    end

    for (genvar i = 0; i < WICLINES; i++) begin : g_line
        cm0_wic_line u_line (
            .sclk         (sclk),
            .hreset_n     (hreset_n),
            .load_en_i    (load_en),
            .clear_i      (wic_clear_i),
            .capture_en_i (capture_en),
            .mask_i       (mask_vec[i]),
            .line_i       (line_vec[i]),
            .sense_o      (wic_sense_o[i]),
            .pend_o       (wic_pend_o[i]),
            .pend_nxt_o   (pend_nxt[i])
        );
    end

endmodule

// File: tb/tb_cm0_wic_ctl.sv
// Directed bench for cm0_wic_ctl: handshake, load/capture, clear priority, abort path, async reset.
module tb_cm0_wic_ctl;

    logic        sclk = 1'b0;
    logic        hreset_n;
    logic        wic_en_req_i, wic_ds_ack_n_i, wic_load_i, wic_clear_i;
    logic [31:0] wic_mask_isr_i, irq_i;
    logic        wic_mask_nmi_i, wic_mask_rxev_i, nmi_i, rxev_i;
    logic        wic_en_ack_o, wic_ds_req_n_o, wakeup_o;
    logic [33:0] wic_sense_o, wic_pend_o;

    int compared   = 0;
    int mismatched = 0;

    always #5 sclk = ~sclk;

    cm0_wic_ctl #(.WICLINES(34)) dut (
        .sclk            (sclk),
        .hreset_n        (hreset_n),
        .wic_en_req_i    (wic_en_req_i),
        .wic_en_ack_o    (wic_en_ack_o),
        .wic_ds_req_n_o  (wic_ds_req_n_o),
        .wic_ds_ack_n_i  (wic_ds_ack_n_i),
        .wic_load_i      (wic_load_i),
        .wic_clear_i     (wic_clear_i),
        .wic_mask_isr_i  (wic_mask_isr_i),
        .wic_mask_nmi_i  (wic_mask_nmi_i),
        .wic_mask_rxev_i (wic_mask_rxev_i),
        .irq_i           (irq_i),
        .nmi_i           (nmi_i),
        .rxev_i          (rxev_i),
        .wic_sense_o     (wic_sense_o),
        .wic_pend_o      (wic_pend_o),
        .wakeup_o        (wakeup_o)
    );

    // Advance one clock and land 1ns past the edge: outputs settled, inputs safe to change.
    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        hreset_n = 1'b0;
        wic_en_req_i = 1'b0; wic_ds_ack_n_i = 1'b1; wic_load_i = 1'b0; wic_clear_i = 1'b0;
        wic_mask_isr_i = '0; wic_mask_nmi_i = 1'b0; wic_mask_rxev_i = 1'b0;
        irq_i = '0; nmi_i = 1'b0; rxev_i = 1'b0;
        step(); step();
        hreset_n = 1'b1;
        step();
        compared++; if (wic_ds_req_n_o !== 1'b1) begin mismatched++; $display("FAIL rst_ds_req_n: got %b want 1", wic_ds_req_n_o); end
        compared++; if (wic_en_ack_o !== 1'b0) begin mismatched++; $display("FAIL rst_en_ack: got %b want 0", wic_en_ack_o); end
        compared++; if (wakeup_o !== 1'b0) begin mismatched++; $display("FAIL rst_wakeup: got %b want 0", wakeup_o); end
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL rst_sense: got %h want 0", wic_sense_o); end
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL rst_pend: got %h want 0", wic_pend_o); end
    endtask

    task automatic test_handshake();
        wic_en_req_i = 1'b1;
        step();  // cycle 1: REQ
        compared++; if (wic_ds_req_n_o !== 1'b0) begin mismatched++; $display("FAIL hs_c1_ds_req_n: got %b want 0", wic_ds_req_n_o); end
        compared++; if (wic_en_ack_o !== 1'b0) begin mismatched++; $display("FAIL hs_c1_en_ack: got %b want 0", wic_en_ack_o); end
        step();  // cycle 2: still REQ, core answers now
        compared++; if (wic_en_ack_o !== 1'b0) begin mismatched++; $display("FAIL hs_c2_en_ack: got %b want 0", wic_en_ack_o); end
        wic_ds_ack_n_i = 1'b0;
        step();  // cycle 3: ON
        compared++; if (wic_en_ack_o !== 1'b1) begin mismatched++; $display("FAIL hs_c3_en_ack: got %b want 1", wic_en_ack_o); end
        compared++; if (wic_ds_req_n_o !== 1'b0) begin mismatched++; $display("FAIL hs_c3_ds_req_n: got %b want 0", wic_ds_req_n_o); end
    endtask

    task automatic test_load_capture();
        wic_load_i = 1'b1; wic_mask_isr_i = 32'h0000_0010; wic_mask_nmi_i = 1'b1; wic_mask_rxev_i = 1'b0;
        step();
        wic_load_i = 1'b0;
        compared++; if (wic_sense_o !== 34'h1_0000_0010) begin mismatched++; $display("FAIL load_sense: got %h want 100000010", wic_sense_o); end
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL load_pend: got %h want 0", wic_pend_o); end
        irq_i[4] = 1'b1;
        step();
        irq_i[4] = 1'b0;
        compared++; if (wic_pend_o !== 34'h0_0000_0010) begin mismatched++; $display("FAIL cap_pend: got %h want 10", wic_pend_o); end
        compared++; if (wakeup_o !== 1'b1) begin mismatched++; $display("FAIL cap_wakeup: got %b want 1", wakeup_o); end
        step(); step();
        compared++; if (wic_pend_o !== 34'h0_0000_0010) begin mismatched++; $display("FAIL sticky_pend: got %h want 10", wic_pend_o); end
        compared++; if (wakeup_o !== 1'b1) begin mismatched++; $display("FAIL sticky_wakeup: got %b want 1", wakeup_o); end
    endtask

    task automatic test_insensitive_and_nmi();
        wic_clear_i = 1'b1;
        step();
        wic_clear_i = 1'b0;
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL clr_pend: got %h want 0", wic_pend_o); end
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL clr_sense: got %h want 0", wic_sense_o); end
        compared++; if (wakeup_o !== 1'b0) begin mismatched++; $display("FAIL clr_wakeup: got %b want 0", wakeup_o); end
        wic_load_i = 1'b1;
        step();
        wic_load_i = 1'b0;
        irq_i[5] = 1'b1;
        step();
        irq_i[5] = 1'b0; rxev_i = 1'b1;
        step();
        rxev_i = 1'b0;
        step();
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL insens_pend: got %h want 0", wic_pend_o); end
        compared++; if (wakeup_o !== 1'b0) begin mismatched++; $display("FAIL insens_wakeup: got %b want 0", wakeup_o); end
        nmi_i = 1'b1;
        step();
        nmi_i = 1'b0;
        compared++; if (wic_pend_o !== 34'h1_0000_0000) begin mismatched++; $display("FAIL nmi_pend: got %h want 100000000", wic_pend_o); end
        compared++; if (wakeup_o !== 1'b1) begin mismatched++; $display("FAIL nmi_wakeup: got %b want 1", wakeup_o); end
    endtask

    task automatic test_load_clear();
        wic_load_i = 1'b1; wic_clear_i = 1'b1;
        wic_mask_isr_i = 32'hFFFF_FFFF; wic_mask_nmi_i = 1'b1; wic_mask_rxev_i = 1'b1;
        step();
        wic_load_i = 1'b0; wic_clear_i = 1'b0;
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL ldclr_sense: got %h want 0", wic_sense_o); end
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL ldclr_pend: got %h want 0", wic_pend_o); end
        compared++; if (wakeup_o !== 1'b0) begin mismatched++; $display("FAIL ldclr_wakeup: got %b want 0", wakeup_o); end
    endtask

    task automatic test_abort_disarm();
        wic_en_req_i = 1'b0;
        step();  // ON -> DISARM
        compared++; if (wic_ds_req_n_o !== 1'b1) begin mismatched++; $display("FAIL dis_ds_req_n: got %b want 1", wic_ds_req_n_o); end
        compared++; if (wic_en_ack_o !== 1'b0) begin mismatched++; $display("FAIL dis_en_ack: got %b want 0", wic_en_ack_o); end
        wic_ds_ack_n_i = 1'b1;
        step();  // DISARM -> OFF
        wic_en_req_i = 1'b1;
        step();  // OFF -> REQ
        compared++; if (wic_ds_req_n_o !== 1'b0) begin mismatched++; $display("FAIL abort_req: got %b want 0", wic_ds_req_n_o); end
        wic_en_req_i = 1'b0;
        step();  // REQ -> DISARM before any ack
        compared++; if (wic_ds_req_n_o !== 1'b1) begin mismatched++; $display("FAIL abort_disarm: got %b want 1", wic_ds_req_n_o); end
        wic_ds_ack_n_i = 1'b0; wic_en_req_i = 1'b1; wic_load_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++; if (wic_ds_req_n_o !== 1'b1 || wic_en_ack_o !== 1'b0) begin
                mismatched++; $display("FAIL hold_disarm[%0d]: got req_n=%b ack=%b want 1/0", i, wic_ds_req_n_o, wic_en_ack_o);
            end
            compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL hold_load_ign[%0d]: got %h want 0", i, wic_sense_o); end
        end
        wic_ds_ack_n_i = 1'b1;
        step();  // DISARM -> OFF
        compared++; if (wic_ds_req_n_o !== 1'b1) begin mismatched++; $display("FAIL off_ds_req_n: got %b want 1", wic_ds_req_n_o); end
        step();  // OFF -> REQ (en_req still high)
        compared++; if (wic_ds_req_n_o !== 1'b0) begin mismatched++; $display("FAIL rereq_ds_req_n: got %b want 0", wic_ds_req_n_o); end
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL off_load_ign: got %h want 0", wic_sense_o); end
        wic_load_i = 1'b0; wic_ds_ack_n_i = 1'b0;
        step();  // REQ -> ON; load seen in REQ was ignored
        compared++; if (wic_en_ack_o !== 1'b1) begin mismatched++; $display("FAIL reon_en_ack: got %b want 1", wic_en_ack_o); end
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL req_load_ign: got %h want 0", wic_sense_o); end
    endtask

    task automatic test_async_reset();
        wic_load_i = 1'b1; wic_mask_isr_i = 32'h0000_0010; wic_mask_nmi_i = 1'b1; wic_mask_rxev_i = 1'b0;
        step();
        wic_load_i = 1'b0; irq_i[4] = 1'b1;
        step();
        irq_i[4] = 1'b0;
        compared++; if (wic_pend_o !== 34'h0_0000_0010) begin mismatched++; $display("FAIL ar_pre_pend: got %h want 10", wic_pend_o); end
        #2;
        hreset_n = 1'b0;
        #1;
        compared++; if (wic_ds_req_n_o !== 1'b1) begin mismatched++; $display("FAIL ar_ds_req_n: got %b want 1", wic_ds_req_n_o); end
        compared++; if (wic_en_ack_o !== 1'b0) begin mismatched++; $display("FAIL ar_en_ack: got %b want 0", wic_en_ack_o); end
        compared++; if (wakeup_o !== 1'b0) begin mismatched++; $display("FAIL ar_wakeup: got %b want 0", wakeup_o); end
        compared++; if (wic_sense_o !== 34'h0) begin mismatched++; $display("FAIL ar_sense: got %h want 0", wic_sense_o); end
        compared++; if (wic_pend_o !== 34'h0) begin mismatched++; $display("FAIL ar_pend: got %h want 0", wic_pend_o); end
        step();
        hreset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_load_capture();
        test_insensitive_and_nmi();
        test_load_clear();
        test_abort_disarm();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
